// File: rtl/mult_div_unit_pkg.sv
// Purpose: shared op encodings, FSM state encoding and helpers for mult_div_unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   MD_MULT / MD_DIV : values of the op input.
//   MD_ITER          : iteration cycles per operation (one operand bit per cycle).
//   md_state_e       : control FSM states.
//   md_abs           : two's complement magnitude; 0x80000000 maps to 2^31 unsigned.
package mult_div_unit_pkg;

    localparam logic       MD_MULT = 1'b0;
    localparam logic       MD_DIV  = 1'b1;
    localparam logic [5:0] MD_ITER = 6'd32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MULT   = 2'd1,
        ST_DIV    = 2'd2,
        ST_FINISH = 2'd3
    } md_state_e;

    // Magnitude of a two's complement word, read as unsigned.
    function automatic logic [31:0] md_abs(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Purpose: iterative signed 32x32 multiply (radix-2 Booth) and signed divide (restoring).
// Latency: start sampled at edge N -> hi/lo update at edge N+33 (N+2 for divide by zero); done pulses the following cycle.
// Backpressure: start is accepted only while idle; requests while busy are dropped, outputs never stall.
//
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous active-high reset
//   start    in   operation request, accepted only in IDLE
//   op       in   0 = MULT, 1 = DIV
//   a        in   multiplicand / dividend (two's complement)
//   b        in   multiplier / divisor (two's complement)
//   hi       out  product[63:32] / remainder
//   lo       out  product[31:0]  / quotient
//   busy     out  operation in progress
//   done     out  one-cycle completion pulse
//   div_zero out  last divide had a zero divisor; cleared by the next accepted start
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    md_state_e   state_q,    state_d;
    logic [5:0]  cnt_q,      cnt_d;       // shared iteration counter
    logic [63:0] work_q,     work_d;      // shared working register
    logic [31:0] operand_q,  operand_d;   // multiplicand, or divisor magnitude
    logic        acc_ext_q,  acc_ext_d;   // 33rd bit of the Booth accumulator
    logic        booth_q,    booth_d;     // Booth q[-1] bit
    logic        op_q,       op_d;
    logic        quo_neg_q,  quo_neg_d;   // quotient must be negated at FINISH
    logic        rem_neg_q,  rem_neg_d;   // remainder must be negated at FINISH
    logic [31:0] hi_q,       hi_d;
    logic [31:0] lo_q,       lo_d;
    logic        done_q,     done_d;
    logic        div_zero_q, div_zero_d;

    // ------------------------------------------------------------------
    // Booth step
    // work_q[63:32] is the accumulator, work_q[31:0] the shifting multiplier.
    // The accumulator carries a 33rd bit (acc_ext_q) because adding or
    // subtracting a 0x80000000 multiplicand can leave a value that needs it.
    // ------------------------------------------------------------------
    logic [32:0] acc_s;
    logic [32:0] mcand_s;
    logic [33:0] booth_sum;

    always_comb begin
        acc_s   = {acc_ext_q, work_q[63:32]};
        mcand_s = {operand_q[31], operand_q};
        unique case ({work_q[0], booth_q})
            2'b01:   booth_sum = {acc_s[32], acc_s} + {mcand_s[32], mcand_s};
            2'b10:   booth_sum = {acc_s[32], acc_s} - {mcand_s[32], mcand_s};
            default: booth_sum = {acc_s[32], acc_s};
        endcase
    end

    // ------------------------------------------------------------------
    // Restoring divide step on magnitudes
    // work_q[63:32] is the partial remainder, work_q[31:0] starts as the
    // dividend magnitude and fills with quotient bits from the LSB end.
    // The remainder stays below the divisor (<= 2^31), so one extra bit is
    // enough for the shifted remainder and the trial subtraction.
    // ------------------------------------------------------------------
    logic [32:0] rem_shift;
    logic [32:0] div_diff;
    logic        div_fits;

    always_comb begin
        rem_shift = {work_q[63:32], work_q[31]};
        div_diff  = rem_shift - {1'b0, operand_q};
        div_fits  = ~div_diff[32];
    end

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        operand_d  = operand_q;
        acc_ext_d  = acc_ext_q;
        booth_d    = booth_q;
        op_d       = op_q;
        quo_neg_d  = quo_neg_q;
        rem_neg_d  = rem_neg_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d       = op;
                    cnt_d      = 6'd0;
                    acc_ext_d  = 1'b0;
                    booth_d    = 1'b0;
                    div_zero_d = 1'b0;
                    if (op == MD_MULT) begin
                        operand_d = a;
                        work_d    = {32'd0, b};
                        quo_neg_d = 1'b0;
                        rem_neg_d = 1'b0;
                        state_d   = ST_MULT;
                    end else begin
                        operand_d = md_abs(b);
                        work_d    = {32'd0, md_abs(a)};
                        quo_neg_d = a[31] ^ b[31];
                        rem_neg_d = a[31];
                        state_d   = ST_DIV;
                    end
                end
            end

            ST_MULT: begin
                acc_ext_d = booth_sum[33];
                work_d    = {booth_sum[32:0], work_q[31:1]};
                booth_d   = work_q[0];
                cnt_d     = cnt_q + 6'd1;
                if (cnt_q == MD_ITER - 6'd1) begin
                    state_d = ST_FINISH;
                end
            end

            ST_DIV: begin
                // A zero divisor skips the iterations; FINISH flags it.
                if (operand_q == 32'd0) begin
                    state_d = ST_FINISH;
                end else begin
                    if (div_fits) begin
                        work_d = {div_diff[31:0], work_q[30:0], 1'b1};
                    end else begin
                        work_d = {rem_shift[31:0], work_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == MD_ITER - 6'd1) begin
                        state_d = ST_FINISH;
                    end
                end
            end

            ST_FINISH: begin
                done_d  = 1'b1;
                cnt_d   = 6'd0;
                state_d = ST_IDLE;
                if (op_q == MD_MULT) begin
                    // Product fits in 64 bits, so the 33rd accumulator bit is dropped.
                    hi_d = work_q[63:32];
                    lo_d = work_q[31:0];
                end else if (operand_q == 32'd0) begin
                    div_zero_d = 1'b1;
                end else begin
                    // 2^31 quotient negated wraps back to 0x80000000.
                    lo_d = quo_neg_q ? (32'd0 - work_q[31:0])  : work_q[31:0];
                    hi_d = rem_neg_q ? (32'd0 - work_q[63:32]) : work_q[63:32];
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 6'd0;
            work_q     <= 64'd0;
            operand_q  <= 32'd0;
            acc_ext_q  <= 1'b0;
            booth_q    <= 1'b0;
            op_q       <= 1'b0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            operand_q  <= operand_d;
            acc_ext_q  <= acc_ext_d;
            booth_q    <= booth_d;
            op_q       <= op_d;
            quo_neg_q  <= quo_neg_d;
            rem_neg_q  <= rem_neg_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Purpose: self-checking bench for mult_div_unit against a plain-arithmetic reference.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    int total = 0;
    int bad   = 0;

    // Reference architectural state: what hi/lo/div_zero should hold.
    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;
    logic        exp_dz = 1'b0;

    localparam int BOUND = 80;

    mult_div_unit dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference model: signed arithmetic on 64-bit integers.
    task automatic model(input logic o, input logic [31:0] x, input logic [31:0] y,
                         output int exp_lat);
        longint sx, sy, p, q, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o == 1'b0) begin
            p = sx * sy;
            exp_hi = p[63:32];
            exp_lo = p[31:0];
            exp_dz = 1'b0;
            exp_lat = 33;
        end else if (y == 32'd0) begin
            exp_dz = 1'b1;
            exp_lat = 2;
        end else begin
            q = sx / sy;
            r = sx % sy;
            exp_lo = q[31:0];
            exp_hi = r[31:0];
            exp_dz = 1'b0;
            exp_lat = 33;
        end
    endtask

    // Issue one operation; optionally pulse a stray start at cycle poke_at
    // and/or assert reset at cycle abort_at (0 = never).
    task automatic run(input string tag, input logic o, input logic [31:0] x,
                       input logic [31:0] y, input int poke_at, input int abort_at);
        int lat, exp_lat;
        logic hold_ok, busy_ok, aborted, dz_early;
        logic [31:0] old_hi, old_lo;
        old_hi = exp_hi;
        old_lo = exp_lo;
        hold_ok = 1'b1;
        busy_ok = 1'b1;
        aborted = 1'b0;
        dz_early = 1'b0;

        @(negedge clock);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clock);
        #1;
        start = 1'b0; op = ~o; a = $urandom; b = $urandom;

        lat = 0;
        while (lat < BOUND) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
            start = 1'b0;
            reset = 1'b0;
            if (lat == 1) dz_early = div_zero;
            if (done) break;
            if (!aborted) begin
                if (hi !== old_hi || lo !== old_lo) hold_ok = 1'b0;
                if (busy !== 1'b1) busy_ok = 1'b0;
            end
            if (lat == poke_at) begin
                start = 1'b1; op = ~o; a = $urandom; b = $urandom;
            end
            if (lat == abort_at) begin
                reset = 1'b1;
                aborted = 1'b1;
            end
        end

        if (abort_at > 0) begin
            exp_hi = 32'd0;
            exp_lo = 32'd0;
            exp_dz = 1'b0;
            chk({tag, "_nodone"}, 64'(lat), 64'(BOUND));
            chk({tag, "_hi"},   64'(hi),   64'(exp_hi));
            chk({tag, "_lo"},   64'(lo),   64'(exp_lo));
            chk({tag, "_busy"}, 64'(busy), 64'd0);
            chk({tag, "_dz"},   64'(div_zero), 64'd0);
            chk({tag, "_hold"}, 64'(hold_ok), 64'd1);
            return;
        end

        model(o, x, y, exp_lat);
        chk({tag, "_lat"},     64'(lat),      64'(exp_lat));
        chk({tag, "_hi"},      64'(hi),       64'(exp_hi));
        chk({tag, "_lo"},      64'(lo),       64'(exp_lo));
        chk({tag, "_dz"},      64'(div_zero), 64'(exp_dz));
        chk({tag, "_dzclr"},   64'(dz_early), 64'd0);
        chk({tag, "_hold"},    64'(hold_ok),  64'd1);
        chk({tag, "_busy"},    64'(busy_ok),  64'd1);
        chk({tag, "_idle"},    64'(busy),     64'd0);
        @(negedge clock);
        chk({tag, "_pulse"},   64'(done),     64'd0);
    endtask

    initial begin
        logic        ro;
        logic [31:0] rx, ry;
        int          mode;

        // Reset with start held high: the request must be ignored.
        reset = 1'b1; start = 1'b1; op = 1'b0; a = 32'd5; b = 32'd7;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0; start = 1'b0;
        @(negedge clock);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi",   64'(hi),   64'd0);
        chk("rst_lo",   64'(lo),   64'd0);
        chk("rst_dz",   64'(div_zero), 64'd0);

        run("m7x-3", 1'b0, 32'd7, 32'hFFFFFFFD, 0, 0);
        chk("m7x-3_hi_k", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        chk("m7x-3_lo_k", 64'(lo), 64'h0000_0000_FFFF_FFEB);

        run("mmax", 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0);
        chk("mmax_hi_k", 64'(hi), 64'h0000_0000_3FFF_FFFF);
        chk("mmax_lo_k", 64'(lo), 64'h0000_0000_0000_0001);

        run("mmin", 1'b0, 32'h80000000, 32'h80000000, 0, 0);
        chk("mmin_hi_k", 64'(hi), 64'h0000_0000_4000_0000);
        chk("mmin_lo_k", 64'(lo), 64'd0);

        run("d-7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 0, 0);
        chk("d-7/2_lo_k", 64'(lo), 64'h0000_0000_FFFF_FFFD);
        chk("d-7/2_hi_k", 64'(hi), 64'h0000_0000_FFFF_FFFF);

        run("d5/0", 1'b1, 32'd5, 32'd0, 0, 0);
        chk("d5/0_dz_k", 64'(div_zero), 64'd1);
        chk("d5/0_hi_k", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        chk("d5/0_lo_k", 64'(lo), 64'h0000_0000_FFFF_FFFD);

        run("dwrap", 1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 0);
        chk("dwrap_lo_k", 64'(lo), 64'h0000_0000_8000_0000);
        chk("dwrap_hi_k", 64'(hi), 64'd0);
        chk("dwrap_dz_k", 64'(div_zero), 64'd0);

        run("ign", 1'b0, 32'h12345678, 32'hFEDCBA98, 10, 0);
        run("d0/-5", 1'b1, 32'd0, 32'hFFFFFFFB, 0, 0);
        run("abort", 1'b0, 32'h0BADF00D, 32'h00C0FFEE, 10, 20);
        run("post", 1'b0, 32'hFFFFFFFF, 32'h00000009, 0, 0);
        run("d7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 3, 0);

        for (int i = 0; i < 24; i++) begin
            ro = 1'($urandom_range(0, 1));
            rx = $urandom;
            if ($urandom_range(0, 5) == 0) rx = 32'h80000000;
            mode = $urandom_range(0, 7);
            case (mode)
                0:       ry = 32'd0;
                1:       ry = $urandom_range(1, 15);
                2:       ry = 32'hFFFFFFFF;
                3:       ry = 32'h80000000;
                default: ry = $urandom;
            endcase
            run("rnd", ro, rx, ry, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clock and reset as elsewhere in the codebase.
REQ-002 The block SHALL expose these ports: clock  in  1  rising-edge clock.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 start  in  1  operation request from the control unit, sampled on each rising edge.
REQ-005 op  in  1  operation select: 0 = MULT, 1 = DIV.
REQ-006 a  in  32  first operand (rs): multiplicand or dividend, two's complement.
REQ-007 b  in  32  second operand (rt): multiplier or divisor, two's complement.
REQ-008 hi  out  32  HI result: product[63:32] or remainder.
REQ-009 lo  out  32  LO result: product[31:0] or quotient.
REQ-010 busy  out  1  high while an operation is in progress.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 div_zero  out  1  divide-by-zero flag.

Function
REQ-013 The FSM SHALL have four states: IDLE, MULT, DIV, FINISH.
- IDLE + start: latch a, b, op; go to MULT (op=0) or DIV (op=1).
- MULT/DIV: run 32 iteration cycles, then go to FINISH.
- FINISH: go to IDLE.
REQ-014 start SHALL be accepted only in IDLE; start during MULT, DIV or FINISH SHALL be ignored without affecting the running operation.
REQ-015 busy SHALL be 1 in MULT, DIV and FINISH, and 0 in IDLE.
REQ-016 MULT SHALL compute the signed 64-bit product {hi,lo} = a*b using radix-2 Booth, one bit per cycle.
REQ-017 DIV SHALL perform signed division, truncating toward zero:
- lo = quotient; hi = remainder.
- The remainder takes the sign of the dividend.
- Implementation: restoring division on magnitudes, with sign correction in FINISH.
REQ-018 Latency: if start is sampled at edge N, hi and lo SHALL update at edge N+33 and done SHALL be 1 for the single cycle following that edge.
REQ-019 hi and lo SHALL hold their values until the next successful completion and SHALL NOT show intermediate values.
REQ-020 DIV with b == 0:
- DIV goes to FINISH after 1 cycle, so done follows edge N+2.
- div_zero is set to 1; hi and lo are unchanged.
REQ-021 div_zero SHALL clear on the next accepted start.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000 (wrap) and hi = 0x00000000, with no flag.
REQ-023 Operand inputs SHALL be don't-care after the accept edge.

Reset
REQ-024 On reset the unit SHALL go to IDLE and clear hi, lo, busy, done, div_zero and all internal registers to 0.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-026 start asserted together with reset SHALL be ignored.

Structure
REQ-027 The shared control/datapath package SHALL hold:
- op encodings MD_MULT=0 and MD_DIV=1;
- the FSM state encoding;
- the constant MD_ITER=32.
REQ-028 mult and div SHALL share one 6-bit iteration counter and one 64-bit working register; no sub-module is required.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- MULT a=7, b=0xFFFFFFFD (-3) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulses exactly 33 edges after start.
- MULT a=0x7FFFFFFF, b=0x7FFFFFFF -> hi=0x3FFFFFFF, lo=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=5, b=0 -> done after 2 edges, div_zero=1, hi/lo keep previous values; next start clears div_zero.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- Start a MULT, pulse start again at cycle 10 (ignored), then assert reset at cycle 20 -> no done, all outputs 0; a new MULT then completes normally.
